hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Producer-side companion of the EX-stage forwarding unit: detects the hazards forwarding cannot
//  resolve and generates pipeline stall/bubble controls. Covers load-use, multi-cycle MDU
//  (mul/div) results tracked by a register scoreboard, MDU structural conflicts, and
//  data-memory wait states via a small freeze FSM with timeout. Sits beside ID/EX and drives
//  the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register enables.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive dmem_ready-low cycles in WAIT before mem_err; range 2..255
//  CNT_W        8   width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT
// PORTS
//  clk          in   1   pipeline clock
//  rst_n        in   1   asynchronous active-low reset
//  valid_ID     in   1   ID holds a real instruction
//  rs1_ID       in   5   ID source reg 1
//  rs2_ID       in   5   ID source reg 2
//  rs1_used_ID  in   1   instruction in ID reads rs1
//  rs2_used_ID  in   1   instruction in ID reads rs2
//  mdu_op_ID    in   1   instruction in ID is an MDU op
//  valid_EX     in   1   EX holds a real instruction
//  rd_EX        in   5   EX destination
//  regwrite_EX  in   1   EX writes rd
//  memread_EX   in   1   EX is a load
//  mdu_start_EX in   1   EX issues an MDU op this cycle
//  mdu_busy     in   1   MDU is computing
//  mdu_wb       in   1   MDU result written to regfile this cycle
//  mdu_rd       in   5   destination of that MDU result
//  memaccess_MEM in  1   MEM holds a load/store
//  dmem_ready   in   1   data memory completes access this cycle
//  stall_IF     out  1   hold PC
//  stall_ID     out  1   hold IF/ID
//  bubble_EX    out  1   insert NOP into ID/EX
//  freeze       out  1   hold ID/EX, EX/MEM; insert NOP into MEM/WB
//  mem_err      out  1   one-cycle pulse: memory access timed out
// BEHAVIOUR
//  Reset: busy[31:0]=0, state=IDLE, wait_cnt=0, mem_err=0; all stall outputs 0 while reset is asserted.
//  Register x0 is never busy and never causes a hazard (busy[0] tied 0; rd==0 ignored).
//  Freeze FSM (registered state):
//   IDLE: memaccess_MEM && !dmem_ready -> WAIT, wait_cnt=1. Else stay.
//   WAIT: dmem_ready -> IDLE, wait_cnt=0. wait_cnt==MEM_TIMEOUT -> IDLE, mem_err=1 next cycle.
//         Else wait_cnt+1.
//   freeze = memaccess_MEM && !dmem_ready (combinational); a 1-cycle-latency memory therefore
//   costs zero extra cycles; a timeout releases freeze regardless of dmem_ready.
//  Load-use: valid_ID && valid_EX && memread_EX && regwrite_EX && rd_EX!=0 &&
//   ((rs1_used_ID && rs1_ID==rd_EX) || (rs2_used_ID && rs2_ID==rd_EX)).
//  Scoreboard: on posedge, if mdu_start_EX && rd_EX!=0 && !freeze, set busy[rd_EX];
//   if mdu_wb, clear busy[mdu_rd]. Same register set and cleared in one cycle: set wins.
//   sb_hit = valid_ID && any used rsN with (busy[rsN] && !(mdu_wb && mdu_rd==rsN)).
//   (Regfile is write-through, so a register being written back this cycle is not a hazard.)
//  Structural: mdu_conf = valid_ID && mdu_op_ID && (mdu_busy || mdu_start_EX).
//  Outputs (combinational, priority):
//   freeze=1          -> stall_IF=1, stall_ID=1, bubble_EX=0 (whole front end held).
//   else hazard=load-use|sb_hit|mdu_conf -> stall_IF=1, stall_ID=1, bubble_EX=1.
//   else all 0.
//  Load-use stalls exactly one cycle; sb_hit/mdu_conf stall until the condition clears.
//  mem_err is registered, high exactly one cycle, independent of other stalls.
//  Reset mid-operation: state, counter and scoreboard clear immediately (async); no pending
//   MDU result is remembered.
// STRUCTURE
//  riscvx_pkg: REG_AW=5, NUM_REGS=32, freeze FSM state encoding (IDLE=1'b0, WAIT=1'b1).
//  Sub-module hazard_scoreboard: busy vector with set/clear ports and two combinational
//   lookup ports (rs1/rs2 -> busy, bypassing the same-cycle clear); top holds FSM and priority logic.
// TESTING
//  1 lw x5 in EX (memread_EX=1,rd_EX=5), ID reads rs1=5 -> stall_IF=stall_ID=bubble_EX=1 for 1 cycle.
//  2 mdu_start_EX rd=7; next 10 cycles ID reads rs2=7 -> stalled; mdu_wb rd=7 cycle -> no stall.
//  3 Load-use on rd_EX=0 or rs2_used_ID=0 with match -> no stall; busy[0] never set.
//  4 memaccess_MEM=1, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, bubble_EX=0, then IDLE.
//  5 dmem_ready held low, MEM_TIMEOUT=4 -> mem_err pulses once, state IDLE, freeze released.
//  6 Same-cycle mdu_start_EX rd=9 and mdu_wb rd=9 -> busy[9]=1; rst_n low mid-WAIT -> all cleared.

Source files
------------

// File: rtl/riscvx_pkg.sv
// Shared constants and types for the hazard unit slice: register index
// width/count and the freeze FSM state encoding.
package riscvx_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  // Freeze FSM encoding kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side (master) drives
// the ID/EX/MEM status and data-memory handshake; the hazard unit (slave)
// returns the stall/bubble/freeze controls and the timeout pulse.
interface hazard_unit_if;
  import riscvx_pkg::*;

  logic     valid_ID;
  reg_idx_t rs1_ID;
  reg_idx_t rs2_ID;
  logic     rs1_used_ID;
  logic     rs2_used_ID;
  logic     mdu_op_ID;
  logic     valid_EX;
  reg_idx_t rd_EX;
  logic     regwrite_EX;
  logic     memread_EX;
  logic     mdu_start_EX;
  logic     mdu_busy;
  logic     mdu_wb;
  reg_idx_t mdu_rd;
  logic     memaccess_MEM;
  logic     dmem_ready;

  logic     stall_IF;
  logic     stall_ID;
  logic     bubble_EX;
  logic     freeze;
  logic     mem_err;

  modport master (
    output valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, mdu_op_ID,
           valid_EX, rd_EX, regwrite_EX, memread_EX, mdu_start_EX,
           mdu_busy, mdu_wb, mdu_rd, memaccess_MEM, dmem_ready,
    input  stall_IF, stall_ID, bubble_EX, freeze, mem_err
  );

  modport slave (
    input  valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, mdu_op_ID,
           valid_EX, rd_EX, regwrite_EX, memread_EX, mdu_start_EX,
           mdu_busy, mdu_wb, mdu_rd, memaccess_MEM, dmem_ready,
    output stall_IF, stall_ID, bubble_EX, freeze, mem_err
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for in-flight MDU results. One bit per
// architectural register; x0 is never marked busy. Lookups ignore a bit
// that is being cleared this cycle because the regfile writes through.
module hazard_scoreboard
  import riscvx_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_rd,
  input  logic     clr_en,
  input  reg_idx_t clr_rd,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     busy_rs1,
  output logic     busy_rs2
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Next busy vector: clear first so a same-register set in the same cycle wins.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy state register, wiped by reset so no pending result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy_rs1 = busy_q[rs1] && !(clr_en && (clr_rd == rs1));
  assign busy_rs2 = busy_q[rs2] && !(clr_en && (clr_rd == rs2));

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection beside ID/EX: load-use, MDU scoreboard and MDU structural
// hazards produce stall+bubble; a data-memory wait freezes the whole pipe,
// with a timeout that releases the freeze and pulses mem_err.
//
//  state | meaning
//  IDLE  | no outstanding slow memory access
//  WAIT  | MEM access waiting on dmem_ready, wait_cnt counts low cycles
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz
);
  import riscvx_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             mem_err_q, err_nxt;
  logic             timeout;
  logic             freeze_c;
  logic             busy_rs1, busy_rs2;
  logic             load_use, sb_hit, mdu_conf, hazard;

  assign timeout  = (state == ST_WAIT) && (wait_cnt == TIMEOUT_CNT);
  assign freeze_c = rst_n && hz.memaccess_MEM && !hz.dmem_ready && !timeout;

  // Freeze FSM next state: count consecutive not-ready cycles, give up at the limit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hz.memaccess_MEM && !hz.dmem_ready) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (hz.dmem_ready) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Freeze FSM registers and the one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= cnt_nxt;
      mem_err_q <= err_nxt;
    end
  end

  // An MDU op issued while frozen does not leave EX, so it must not mark busy yet.
  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (hz.mdu_start_EX && (hz.rd_EX != '0) && !freeze_c),
    .set_rd   (hz.rd_EX),
    .clr_en   (hz.mdu_wb),
    .clr_rd   (hz.mdu_rd),
    .rs1      (hz.rs1_ID),
    .rs2      (hz.rs2_ID),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );

  // Hazard sources that forwarding cannot cover.
  always_comb begin
    load_use = hz.valid_ID && hz.valid_EX && hz.memread_EX && hz.regwrite_EX &&
               (hz.rd_EX != '0) &&
               ((hz.rs1_used_ID && (hz.rs1_ID == hz.rd_EX)) ||
                (hz.rs2_used_ID && (hz.rs2_ID == hz.rd_EX)));
    sb_hit   = hz.valid_ID &&
               ((hz.rs1_used_ID && busy_rs1) || (hz.rs2_used_ID && busy_rs2));
    mdu_conf = hz.valid_ID && hz.mdu_op_ID && (hz.mdu_busy || hz.mdu_start_EX);
    hazard   = load_use || sb_hit || mdu_conf;
  end

  // Output priority: freeze holds everything, otherwise a hazard stalls and bubbles EX.
  always_comb begin
    hz.stall_IF  = 1'b0;
    hz.stall_ID  = 1'b0;
    hz.bubble_EX = 1'b0;
    hz.freeze    = 1'b0;
    if (rst_n) begin
      if (freeze_c) begin
        hz.freeze   = 1'b1;
        hz.stall_IF = 1'b1;
        hz.stall_ID = 1'b1;
      end else if (hazard) begin
        hz.stall_IF  = 1'b1;
        hz.stall_ID  = 1'b1;
        hz.bubble_EX = 1'b1;
      end
    end
  end

  assign hz.mem_err = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the hazard rules.
module tb_hazard_unit;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if hif();

  hazard_unit #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: set of registers awaiting an MDU result, length of the
  // current not-ready run, and a pending timeout pulse.
  bit   busy_m[32];
  int   run_m = 0;
  bit   err_m = 1'b0;

  // {stall_IF, stall_ID, bubble_EX, freeze, mem_err}
  logic [4:0] obs;
  logic [4:0] exp_o;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    run_m = 0;
    err_m = 1'b0;
  endtask

  function automatic logic [4:0] expect_now();
    bit frz, lu, sb, mc, hzd, r1, r2;
    if (!rst_n) return 5'b0;
    frz = hif.memaccess_MEM && !hif.dmem_ready && (run_m != T);
    lu  = hif.valid_ID && hif.valid_EX && hif.memread_EX && hif.regwrite_EX &&
          (hif.rd_EX != 0) &&
          ((hif.rs1_used_ID && hif.rs1_ID == hif.rd_EX) ||
           (hif.rs2_used_ID && hif.rs2_ID == hif.rd_EX));
    r1  = busy_m[hif.rs1_ID] && !(hif.mdu_wb && hif.mdu_rd == hif.rs1_ID);
    r2  = busy_m[hif.rs2_ID] && !(hif.mdu_wb && hif.mdu_rd == hif.rs2_ID);
    sb  = hif.valid_ID && ((hif.rs1_used_ID && r1) || (hif.rs2_used_ID && r2));
    mc  = hif.valid_ID && hif.mdu_op_ID && (hif.mdu_busy || hif.mdu_start_EX);
    hzd = lu || sb || mc;
    return {frz || hzd, frz || hzd, !frz && hzd, frz, err_m};
  endfunction

  task automatic model_step(input bit frz);
    if (hif.mdu_wb) busy_m[hif.mdu_rd] = 1'b0;
    if (hif.mdu_start_EX && hif.rd_EX != 0 && !frz) busy_m[hif.rd_EX] = 1'b1;
    err_m = 1'b0;
    if (run_m == 0) begin
      if (hif.memaccess_MEM && !hif.dmem_ready) run_m = 1;
    end else if (hif.dmem_ready) begin
      run_m = 0;
    end else if (run_m == T) begin
      run_m = 0;
      err_m = 1'b1;
    end else begin
      run_m++;
    end
  endtask

  task automatic idle_in();
    hif.valid_ID = 0; hif.rs1_ID = 0; hif.rs2_ID = 0;
    hif.rs1_used_ID = 0; hif.rs2_used_ID = 0; hif.mdu_op_ID = 0;
    hif.valid_EX = 0; hif.rd_EX = 0; hif.regwrite_EX = 0; hif.memread_EX = 0;
    hif.mdu_start_EX = 0; hif.mdu_busy = 0; hif.mdu_wb = 0; hif.mdu_rd = 0;
    hif.memaccess_MEM = 0; hif.dmem_ready = 1;
  endtask

  // One pipeline cycle: inputs already driven; check mid-cycle, then advance.
  task automatic cyc();
    @(negedge clk);
    exp_o = expect_now();
    obs = {hif.stall_IF, hif.stall_ID, hif.bubble_EX, hif.freeze, hif.mem_err};
    chk("outs", 32'(obs), 32'(exp_o));
    model_step(exp_o[1]);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      3: return 5'd9;
      4: return 5'd12;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  int cnt_a, cnt_b;

  initial begin
    model_reset();
    idle_in();
    // Reset with a load-use pattern present: outputs must stay low.
    hif.valid_ID = 1; hif.rs1_ID = 5; hif.rs1_used_ID = 1;
    hif.valid_EX = 1; hif.rd_EX = 5; hif.memread_EX = 1; hif.regwrite_EX = 1;
    hif.memaccess_MEM = 1; hif.dmem_ready = 0;
    #12;
    chk("rst_outs", 32'({hif.stall_IF, hif.stall_ID, hif.bubble_EX, hif.freeze, hif.mem_err}), 32'd0);
    idle_in();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Load-use: one stall cycle, then the bubble leaves EX empty.
    hif.valid_ID = 1; hif.rs1_ID = 5; hif.rs1_used_ID = 1;
    hif.valid_EX = 1; hif.rd_EX = 5; hif.memread_EX = 1; hif.regwrite_EX = 1;
    cyc();
    chk("lu_stall", 32'(obs), 32'(5'b11100));
    hif.valid_EX = 0; hif.memread_EX = 0; hif.regwrite_EX = 0;
    cyc();
    chk("lu_release", 32'(obs[4:2]), 32'd0);

    // Scoreboard: MDU to x7, ID reads rs2=7 for ten cycles, writeback releases.
    idle_in();
    hif.valid_EX = 1; hif.rd_EX = 7; hif.regwrite_EX = 1; hif.mdu_start_EX = 1;
    cyc();
    idle_in();
    hif.valid_ID = 1; hif.rs2_ID = 7; hif.rs2_used_ID = 1;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (obs[3] && obs[2]) cnt_a++;
    end
    chk("sb_stall10", 32'(cnt_a), 32'd10);
    hif.mdu_wb = 1; hif.mdu_rd = 7;
    cyc();
    chk("sb_wb_bypass", 32'(obs[3]), 32'd0);
    hif.mdu_wb = 0;
    cyc();
    chk("sb_cleared", 32'(obs[3]), 32'd0);

    // x0 and unused operands never stall; x0 is never marked busy.
    idle_in();
    hif.valid_ID = 1; hif.rs1_ID = 0; hif.rs1_used_ID = 1;
    hif.valid_EX = 1; hif.rd_EX = 0; hif.memread_EX = 1; hif.regwrite_EX = 1;
    cyc();
    chk("lu_x0", 32'(obs[4:2]), 32'd0);
    hif.rs1_used_ID = 0; hif.rs2_ID = 6; hif.rs2_used_ID = 0; hif.rd_EX = 6;
    cyc();
    chk("lu_unused", 32'(obs[4:2]), 32'd0);
    idle_in();
    hif.valid_EX = 1; hif.rd_EX = 0; hif.regwrite_EX = 1; hif.mdu_start_EX = 1;
    cyc();
    idle_in();
    hif.valid_ID = 1; hif.rs1_ID = 0; hif.rs1_used_ID = 1;
    cyc();
    chk("x0_busy", 32'(obs[3]), 32'd0);

    // Memory wait of three cycles with a concurrent load-use: freeze wins.
    idle_in();
    hif.valid_ID = 1; hif.rs1_ID = 5; hif.rs1_used_ID = 1;
    hif.valid_EX = 1; hif.rd_EX = 5; hif.memread_EX = 1; hif.regwrite_EX = 1;
    hif.memaccess_MEM = 1; hif.dmem_ready = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (obs[1]) cnt_a++;
      if (obs[2]) cnt_b++;
    end
    chk("frz_cnt", 32'(cnt_a), 32'd3);
    chk("frz_bubble", 32'(cnt_b), 32'd0);
    hif.dmem_ready = 1;
    cyc();
    chk("frz_release", 32'(obs[4:1]), 32'(4'b1110));

    // Timeout: ready held low; freeze drops at the limit and mem_err pulses once.
    idle_in();
    hif.memaccess_MEM = 1; hif.dmem_ready = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < T + 1; i++) begin
      cyc();
      if (obs[1]) cnt_a++;
      if (obs[0]) cnt_b++;
    end
    chk("to_release", 32'(obs[1]), 32'd0);
    hif.memaccess_MEM = 0; hif.dmem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (obs[0]) cnt_b++;
    end
    chk("to_frz_cnt", 32'(cnt_a), 32'(T));
    chk("to_err_once", 32'(cnt_b), 32'd1);
    hif.memaccess_MEM = 1; hif.dmem_ready = 0;
    cyc();
    chk("to_idle_again", 32'(obs[1]), 32'd1);

    // Same-cycle set and clear of x9: set wins.
    idle_in();
    hif.valid_EX = 1; hif.rd_EX = 9; hif.regwrite_EX = 1; hif.mdu_start_EX = 1;
    hif.mdu_wb = 1; hif.mdu_rd = 9;
    cyc();
    idle_in();
    hif.valid_ID = 1; hif.rs1_ID = 9; hif.rs1_used_ID = 1;
    cyc();
    chk("set_wins", 32'(obs[4:2]), 32'(3'b111));

    // Reset in the middle of a memory wait clears FSM and scoreboard.
    idle_in();
    hif.memaccess_MEM = 1; hif.dmem_ready = 0;
    cyc();
    cyc();
    #2 rst_n = 0;
    #1;
    chk("rst_mid_frz", 32'({hif.stall_IF, hif.stall_ID, hif.freeze}), 32'd0);
    model_reset();
    idle_in();
    @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    hif.valid_ID = 1; hif.rs1_ID = 9; hif.rs1_used_ID = 1;
    cyc();
    chk("rst_sb_clear", 32'(obs[3]), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      hif.valid_ID      = ($urandom_range(0, 3) != 0);
      hif.rs1_ID        = pick_reg();
      hif.rs2_ID        = pick_reg();
      hif.rs1_used_ID   = $urandom_range(0, 1) == 1;
      hif.rs2_used_ID   = $urandom_range(0, 1) == 1;
      hif.mdu_op_ID     = ($urandom_range(0, 4) == 0);
      hif.valid_EX      = ($urandom_range(0, 3) != 0);
      hif.rd_EX         = pick_reg();
      hif.regwrite_EX   = ($urandom_range(0, 3) != 0);
      hif.memread_EX    = ($urandom_range(0, 3) == 0);
      hif.mdu_start_EX  = ($urandom_range(0, 5) == 0);
      hif.mdu_busy      = ($urandom_range(0, 4) == 0);
      hif.mdu_wb        = ($urandom_range(0, 4) == 0);
      hif.mdu_rd        = pick_reg();
      hif.memaccess_MEM = ($urandom_range(0, 2) == 0) || (run_m != 0 && $urandom_range(0, 1) == 1);
      hif.dmem_ready    = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
